digit_unloader: RTL and testbench

Parallel-to-serial counterpart of the digit shift register. It captures a packed COUNT×WIDTH-bit word, such as a display or entry buffer, in one cycle. It then emits the word one WIDTH-bit digit at a time over a valid/ready handshake. It sits between the digit buffer and any digit-serial consumer (UART formatter, display scanner, BCD checker).

---
 rtl/digit_unloader.sv | 125 ++++++++++++
 tb/tb_digit_unloader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/digit_unloader.sv
// digit_unloader: captures a packed COUNT x WIDTH word in one cycle and
// streams it out one digit at a time over a valid/ready handshake.
// The unload order is chosen per word: most significant digit first, or
// least significant digit first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for load; a new word is accepted only here
// ST_SHIFT | presenting the current digit; one shift per accepted digit
// ST_DONE  | one-cycle done pulse after the last digit, then back to IDLE
module digit_unloader #(
    parameter int COUNT = 4,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         dir,
    input  logic                         flush,
    input  logic [COUNT*WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]             out_digit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(COUNT+1)-1:0]   remaining
);

    localparam int              RW       = $clog2(COUNT + 1);
    localparam int              DW       = COUNT * WIDTH;
    localparam logic [RW-1:0]   REM_FULL = RW'(COUNT);
    localparam logic [RW-1:0]   REM_ONE  = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_hold;
    logic [DW-1:0]   w_hold_nxt;
    logic            r_dir_q;
    logic            w_dir_nxt;
    logic [RW-1:0]   r_remaining;
    logic [RW-1:0]   w_remaining_nxt;
    logic            w_xfer;

    // A digit moves only while it is being presented and the consumer takes it.
    assign w_xfer = (r_state == ST_SHIFT) && out_ready;

    // State, hold word, order and digit count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_dir_q     <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_dir_q     <= w_dir_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Next-state logic; flush overrides load and transfer in every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold;
        w_dir_nxt       = r_dir_q;
        w_remaining_nxt = r_remaining;

        if (flush) begin
            w_state_nxt     = ST_IDLE;
            w_hold_nxt      = '0;
            w_dir_nxt       = 1'b0;
            w_remaining_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        w_state_nxt     = ST_SHIFT;
                        w_hold_nxt      = data_in;
                        w_dir_nxt       = dir;
                        w_remaining_nxt = REM_FULL;
                    end
                end
                ST_SHIFT: begin
                    if (w_xfer) begin
                        // Shift the consumed digit out; vacated digits fill with zero.
                        w_hold_nxt      = r_dir_q ? (r_hold >> WIDTH) : (r_hold << WIDTH);
                        w_remaining_nxt = r_remaining - REM_ONE;
                        if (r_remaining == REM_ONE) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_hold_nxt      = '0;
                    w_dir_nxt       = 1'b0;
                    w_remaining_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from registers only, so no input reaches an output combinationally.
    always_comb begin
        out_valid = (r_state == ST_SHIFT);
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        remaining = r_remaining;
        out_digit = '0;
        if (r_state == ST_SHIFT) begin
            out_digit = r_dir_q ? r_hold[WIDTH-1:0] : r_hold[DW-1 -: WIDTH];
        end
    end

endmodule

// File: tb/tb_digit_unloader.sv
// Testbench for digit_unloader: directed scenarios followed by random traffic.
// A word-level model pushes the expected digit sequence into a scoreboard
// queue when a load is accepted; a monitor pops and compares on each handshake.
module tb_digit_unloader;

    localparam int COUNT = 4;
    localparam int WIDTH = 4;
    localparam int RW    = $clog2(COUNT + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    load;
    logic                    dir;
    logic                    flush;
    logic [COUNT*WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]        out_digit;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    done;
    logic [RW-1:0]           remaining;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 streaming, 2 done pulse.
    logic [WIDTH-1:0] exp_q[$];
    int m_phase = 0;
    int m_left  = 0;

    digit_unloader #(.COUNT(COUNT), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .dir       (dir),
        .flush     (flush),
        .data_in   (data_in),
        .out_digit (out_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model advanced at each clock edge from the bench's own drives.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0;
            m_left  = 0;
            exp_q.delete();
        end else if (flush) begin
            m_phase = 0;
            m_left  = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (load) begin
                        exp_q.delete();
                        for (int i = 0; i < COUNT; i++) begin
                            if (dir) exp_q.push_back(data_in[i*WIDTH +: WIDTH]);
                            else     exp_q.push_back(data_in[(COUNT-1-i)*WIDTH +: WIDTH]);
                        end
                        m_left  = COUNT;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (out_ready) begin
                        m_left--;
                        if (m_left == 0) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires digits on handshakes.
    always @(negedge clk) begin
        if (reset) begin
            check("out_valid", out_valid, (m_phase == 1));
            check("busy",      busy,      (m_phase != 0));
            check("done",      done,      (m_phase == 2));
            check("remaining", remaining, m_left);
            if (m_phase == 1) begin
                check("scoreboard_has_digit", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("out_digit", out_digit, exp_q[0]);
            end else begin
                check("out_digit_idle", out_digit, 0);
            end
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    task automatic step(input logic l, input logic d, input logic [COUNT*WIDTH-1:0] x,
                        input logic r, input logic f);
        load      = l;
        dir       = d;
        data_in   = x;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; dir = 1'b0; flush = 1'b0;
        data_in = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_remaining", remaining, 0);
        check("rst_out_digit", out_digit, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        idle(2);

        // MSD-first stream
        step(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        idle(7);

        // LSD-first stream
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
        idle(7);

        // Backpressure after the first transfer
        step(1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(5);

        // Load while busy is ignored; load after done is accepted
        step(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 16'h9876, 1'b1, 1'b0);
        idle(7);

        // Flush after two transfers
        step(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(2);
        step(1'b1, 1'b1, 16'h4321, 1'b1, 1'b0);
        idle(7);

        // Asynchronous reset mid-stream
        step(1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy",      busy,      0);
        check("arst_done",      done,      0);
        check("arst_out_digit", out_digit, 0);
        check("arst_remaining", remaining, 0);
        @(posedge clk);
        #2;
        idle(2);
        #1 reset = 1'b1;
        idle(4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 39) == 0));
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
